// File: rtl/arm_hazard_scoreboard.sv
// Hazard scoreboard beside the ID stage: shadow pipeline of in-flight destinations,
// producing the ID stall and operand forwarding selects. Optional: HAZARD_STALL_CNT_EN adds stall_cycles.
module arm_hazard_scoreboard #(
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned DEPTH      = 3,
    localparam int unsigned SEL_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  use_forwarding,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic                  id_src1_used,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_src2_used,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_wb_en,
    input  logic                  id_is_load,
    output logic                  stall,
    output logic [SEL_W-1:0]      fwd_sel1,
    output logic [SEL_W-1:0]      fwd_sel2
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    logic [DEPTH:1]        v_q;
    logic [DEPTH:1]        wb_q;
    logic [REG_ADDR_W-1:0] dest_q [1:DEPTH];
    // A load's result is forwardable from stage 2 onward, so only stage 1's ld bit is ever consulted.
    logic                  ld1_q;

    logic [DEPTH:1]        m1;
    logic [DEPTH:1]        m2;
    logic [SEL_W-1:0]      sel1;
    logic [SEL_W-1:0]      sel2;
    logic                  load_use;
    logic                  rf_hazard;

    // Shadow shift pipeline; flush kills every stage including the incoming one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q   <= '0;
            wb_q  <= '0;
            ld1_q <= 1'b0;
            for (int k = 1; k <= DEPTH; k++) begin
                dest_q[k] <= '0;
            end
        end else begin
            v_q[1]    <= id_valid & ~stall & ~flush;
            wb_q[1]   <= id_wb_en;
            ld1_q     <= id_is_load;
            dest_q[1] <= id_dest;
            for (int k = 2; k <= DEPTH; k++) begin
                v_q[k]    <= v_q[k-1] & ~flush;
                wb_q[k]   <= wb_q[k-1];
                dest_q[k] <= dest_q[k-1];
            end
        end
    end

    // Per-stage operand matches.
    always_comb begin
        m1 = '0;
        m2 = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            m1[k] = v_q[k] & wb_q[k] & (dest_q[k] == id_src1) & id_src1_used & id_valid;
            m2[k] = v_q[k] & wb_q[k] & (dest_q[k] == id_src2) & id_src2_used & id_valid;
        end
    end

    // Youngest producer wins: scan oldest to youngest so the smallest stage overrides.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (m1[k]) sel1 = SEL_W'(k);
            if (m2[k]) sel2 = SEL_W'(k);
        end
    end

    always_comb begin
        load_use  = (m1[1] | m2[1]) & ld1_q;
        rf_hazard = |(m1[DEPTH-1:1] | m2[DEPTH-1:1]);
        stall     = 1'b0;
        fwd_sel1  = '0;
        fwd_sel2  = '0;
        if (use_forwarding) begin
            stall    = load_use & ~flush;
            fwd_sel1 = sel1;
            fwd_sel2 = sel2;
        end else begin
            stall    = rf_hazard & ~flush;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    // Saturating stall-cycle counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_arm_hazard_scoreboard.sv
// Bench for arm_hazard_scoreboard: directed scenarios plus randomized traffic against a queue model.
module tb_arm_hazard_scoreboard;

    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned DEPTH      = 3;
    localparam int unsigned SEL_W      = 2;

    logic                  clk;
    logic                  rst;
    logic                  use_forwarding;
    logic                  flush;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_src1;
    logic                  id_src1_used;
    logic [REG_ADDR_W-1:0] id_src2;
    logic                  id_src2_used;
    logic [REG_ADDR_W-1:0] id_dest;
    logic                  id_wb_en;
    logic                  id_is_load;
    logic                  stall;
    logic [SEL_W-1:0]      fwd_sel1;
    logic [SEL_W-1:0]      fwd_sel2;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0]           stall_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] dest;
        logic                  wb;
        logic                  ld;
    } ent_t;

    ent_t mq[$];   // index 0 = stage 1 (youngest)
    int   cnt_m;

    arm_hazard_scoreboard #(.REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .use_forwarding(use_forwarding), .flush(flush),
        .id_valid(id_valid), .id_src1(id_src1), .id_src1_used(id_src1_used),
        .id_src2(id_src2), .id_src2_used(id_src2_used), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_is_load(id_is_load), .stall(stall),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2)
`ifdef HAZARD_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input int s1, input logic u1, input int s2, input logic u2,
                         input int d, input logic wb, input logic ld);
        id_valid     = v;
        id_src1      = REG_ADDR_W'(s1);
        id_src1_used = u1;
        id_src2      = REG_ADDR_W'(s2);
        id_src2_used = u2;
        id_dest      = REG_ADDR_W'(d);
        id_wb_en     = wb;
        id_is_load   = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (DEPTH + 1) tick();
    endtask

    function automatic int youngest(input logic [REG_ADDR_W-1:0] src, input logic used);
        if (!used || !id_valid) return 0;
        foreach (mq[i]) if (mq[i].v && mq[i].wb && mq[i].dest == src) return i + 1;
        return 0;
    endfunction

    // Expected outputs from the rules: forwarding picks the youngest producer and only a
    // load sitting in stage 1 stalls; without forwarding, stall until the producer is in the last stage.
    function automatic void model_eval(output logic st, output logic [SEL_W-1:0] s1, output logic [SEL_W-1:0] s2);
        int p1, p2;
        p1 = youngest(id_src1, id_src1_used);
        p2 = youngest(id_src2, id_src2_used);
        if (use_forwarding) begin
            st = mq[0].ld && (p1 == 1 || p2 == 1);
            s1 = SEL_W'(p1);
            s2 = SEL_W'(p2);
        end else begin
            st = (p1 != 0 && p1 < DEPTH) || (p2 != 0 && p2 < DEPTH);
            s1 = '0;
            s2 = '0;
        end
        if (flush) st = 1'b0;
    endfunction

    task automatic model_reset();
        ent_t z;
        z = '0;
        mq = {};
        repeat (DEPTH) mq.push_back(z);
        cnt_m = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        use_forwarding = 1'b1;
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", stall); end
        n_tests++; if (fwd_sel1 !== 2'd0 || fwd_sel2 !== 2'd0) begin n_fail++;
            $display("FAIL reset_sel: got %0d/%0d want 0/0", fwd_sel1, fwd_sel2); end
`ifdef HAZARD_STALL_CNT_EN
        n_tests++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", stall_cycles); end
`endif
        #4 rst = 1'b1;
        tick();
    endtask

    task automatic test_fwd_basic();
        use_forwarding = 1'b1;
        drive(1, 5, 1, 6, 1, 1, 1, 0);   // ADD R1
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fwd_add_stall: got %0b want 0", stall); end
        tick();
        drive(1, 1, 1, 7, 1, 8, 1, 0);   // SUB R8, R1, R7
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fwd_sub_stall: got %0b want 0", stall); end
        n_tests++; if (fwd_sel1 !== 2'd1) begin n_fail++; $display("FAIL fwd_sub_sel1: got %0d want 1", fwd_sel1); end
        n_tests++; if (fwd_sel2 !== 2'd0) begin n_fail++; $display("FAIL fwd_sub_sel2: got %0d want 0", fwd_sel2); end
        tick();
        drain();
    endtask

    task automatic test_load_use();
        use_forwarding = 1'b1;
        drive(1, 0, 0, 0, 0, 2, 1, 1);   // LDR R2
        tick();
        drive(1, 9, 1, 2, 1, 10, 1, 0);  // ADD R10, R9, R2
        #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL ld_use_stall: got %0b want 1", stall); end
        tick();
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ld_use_release: got %0b want 0", stall); end
        n_tests++; if (fwd_sel2 !== 2'd2) begin n_fail++; $display("FAIL ld_use_sel2: got %0d want 2", fwd_sel2); end
        n_tests++; if (fwd_sel1 !== 2'd0) begin n_fail++; $display("FAIL ld_use_sel1: got %0d want 0", fwd_sel1); end
`ifdef HAZARD_STALL_CNT_EN
        n_tests++; if (stall_cycles !== 32'd1) begin n_fail++; $display("FAIL ld_use_cnt: got %0d want 1", stall_cycles); end
`endif
        tick();
        drain();
    endtask

    task automatic test_no_fwd();
        logic [2:0] exp_st;
        exp_st = 3'b011;   // stall while producer in stages 1 and 2
        use_forwarding = 1'b0;
        drive(1, 5, 1, 6, 1, 1, 1, 0);   // ADD R1
        tick();
        drive(1, 1, 1, 7, 1, 8, 1, 0);   // SUB R8, R1, R7 held in ID
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++; if (stall !== exp_st[c]) begin n_fail++;
                $display("FAIL nofwd_stall_c%0d: got %0b want %0b", c, stall, exp_st[c]); end
            n_tests++; if (fwd_sel1 !== 2'd0) begin n_fail++;
                $display("FAIL nofwd_sel1_c%0d: got %0d want 0", c, fwd_sel1); end
            tick();
        end
        use_forwarding = 1'b1;
        drain();
    endtask

    task automatic test_youngest();
        use_forwarding = 1'b1;
        drive(1, 0, 0, 0, 0, 3, 1, 0);   // MOV R3
        tick();
        drive(1, 0, 0, 0, 0, 3, 1, 0);   // MOV R3
        tick();
        drive(1, 3, 1, 0, 0, 11, 1, 0);  // reader of R3
        #1;
        n_tests++; if (fwd_sel1 !== 2'd1) begin n_fail++; $display("FAIL youngest_sel1: got %0d want 1", fwd_sel1); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL youngest_stall: got %0b want 0", stall); end
        tick();
        drain();
    endtask

    task automatic test_flush();
        use_forwarding = 1'b1;
        drive(1, 0, 0, 0, 0, 4, 1, 1);   // LDR R4
        tick();
        drive(1, 4, 1, 0, 0, 12, 1, 0);  // dependent reader
        flush = 1'b1;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %0b want 0", stall); end
        tick();
        flush = 1'b0;
        #1;
        n_tests++; if (fwd_sel1 !== 2'd0) begin n_fail++; $display("FAIL flush_after_sel1: got %0d want 0", fwd_sel1); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_after_stall: got %0b want 0", stall); end
        tick();
        drain();
    endtask

    task automatic test_async_reset();
        use_forwarding = 1'b1;
        drive(1, 0, 0, 0, 0, 5, 1, 0); tick();
        drive(1, 0, 0, 0, 0, 6, 1, 0); tick();
        drive(1, 0, 0, 0, 0, 7, 1, 0); tick();
        drive(1, 5, 1, 6, 1, 13, 1, 0);
        #1;
        n_tests++; if (fwd_sel1 !== 2'd3 || fwd_sel2 !== 2'd2) begin n_fail++;
            $display("FAIL pre_reset_sel: got %0d/%0d want 3/2", fwd_sel1, fwd_sel2); end
        #1 rst = 1'b0;
        #1;
        n_tests++; if (fwd_sel1 !== 2'd0 || fwd_sel2 !== 2'd0 || stall !== 1'b0) begin n_fail++;
            $display("FAIL async_reset_out: got sel %0d/%0d stall %0b want 0/0/0", fwd_sel1, fwd_sel2, stall); end
`ifdef HAZARD_STALL_CNT_EN
        n_tests++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL async_reset_cnt: got %0d want 0", stall_cycles); end
`endif
        #2 rst = 1'b1;
        tick();
        drive(1, 7, 1, 6, 1, 14, 1, 0);
        #1;
        n_tests++; if (fwd_sel1 !== 2'd0 || fwd_sel2 !== 2'd0 || stall !== 1'b0) begin n_fail++;
            $display("FAIL post_reset_out: got sel %0d/%0d stall %0b want 0/0/0", fwd_sel1, fwd_sel2, stall); end
        tick();
        drain();
    endtask

    task automatic test_random();
        logic             st;
        logic [SEL_W-1:0] s1, s2;
        ent_t             e;
        #1 rst = 1'b0;
        #2 rst = 1'b1;
        tick();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) use_forwarding = ~use_forwarding;
            flush = ($urandom_range(0, 15) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
            #1;
            model_eval(st, s1, s2);
            n_tests++; if (stall !== st) begin n_fail++;
                $display("FAIL rand_stall_c%0d: got %0b want %0b", c, stall, st); end
            if (!(use_forwarding && st)) begin
                n_tests++; if (fwd_sel1 !== s1 || fwd_sel2 !== s2) begin n_fail++;
                    $display("FAIL rand_sel_c%0d: got %0d/%0d want %0d/%0d", c, fwd_sel1, fwd_sel2, s1, s2); end
            end
            @(posedge clk);
            e.v = id_valid & ~st & ~flush;
            e.dest = id_dest;
            e.wb = id_wb_en;
            e.ld = id_is_load;
            if (flush) foreach (mq[i]) mq[i].v = 1'b0;
            mq.push_front(e);
            void'(mq.pop_back());
            if (st) cnt_m++;
            #1;
        end
`ifdef HAZARD_STALL_CNT_EN
        n_tests++; if (stall_cycles !== 32'(cnt_m)) begin n_fail++;
            $display("FAIL rand_cnt: got %0d want %0d", stall_cycles, cnt_m); end
`endif
        flush = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_fwd_basic();
        test_load_use();
        test_no_fwd();
        test_youngest();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
